cva6_axi_err_mon: RTL and testbench

CVA6_AXI_ERR_MON -- requirements
Module: cva6_axi_err_mon

---
 rtl/ariane_axi_soc_pkg.sv | 75 +++++++
 rtl/cva6_axi_err_mon_if.sv | 10 +
 rtl/cva6_axi_err_mon_ctr.sv | 37 +++
 rtl/cva6_axi_err_mon.sv | 174 +++++++++++++++++
 tb/tb_cva6_axi_err_mon.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_axi_soc_pkg.sv
// AXI request/response types for the SoC master path, plus the error-capture
// FSM state and capture record shared by the cva6_axi_err_mon slice.
package ariane_axi_soc;

    typedef logic [7:0] id_t;

    typedef struct packed {
        id_t         id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        id_t         id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        IDLE,
        CAPTURED
    } err_state_e;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        logic       is_write;
    } err_capture_t;

    // SLVERR and DECERR both have the upper bit set.
    function automatic logic is_err_resp(logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/cva6_axi_err_mon_if.sv
// One AXI request/response link; the master side drives req, the slave side drives resp.
interface cva6_axi_err_mon_if;
    import ariane_axi_soc::*;

    req_t  req;
    resp_t resp;

    modport master (output req, input  resp);
    modport slave  (input  req, output resp);
endinterface

// File: rtl/cva6_axi_err_mon_ctr.sv
// Outstanding-transaction up/down counter: saturates at MAX, clamps at zero.
module cva6_axi_err_mon_ctr #(
    parameter int unsigned MAX   = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && !dec_i) begin
            if (r_cnt != WIDTH'(MAX)) r_cnt <= r_cnt + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

`ifndef SYNTHESIS
    // A response arriving with nothing in flight (e.g. after a mid-transaction reset).
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(dec_i && !inc_i && r_cnt == '0))
                else $warning("cva6_axi_err_mon_ctr: underflow clamped at zero");
        end
    end
`endif

    assign cnt_o = r_cnt;

endmodule

// File: rtl/cva6_axi_err_mon.sv
// AXI error monitor between the ID remapper and the CDC source.
// Optional watchdog enabled by defining CVA6_AXI_ERR_MON_TIMEOUT_EN.
module cva6_axi_err_mon
    import ariane_axi_soc::*;
#(
    parameter int unsigned AXI_ID_WIDTH    = 8,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter type         req_t           = ariane_axi_soc::req_t,
    parameter type         resp_t          = ariane_axi_soc::resp_t
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  req_t                                 slv_req_i,
    output resp_t                                slv_resp_o,
    output req_t                                 mst_req_o,
    input  resp_t                                mst_resp_i,
    input  logic                                 clr_i,
    output logic [CNT_WIDTH-1:0]                 r_err_cnt_o,
    output logic [CNT_WIDTH-1:0]                 b_err_cnt_o,
    output logic                                 err_valid_o,
    output logic [AXI_ID_WIDTH-1:0]              err_id_o,
    output logic [1:0]                           err_resp_o,
    output logic                                 err_is_write_o,
    output logic [$clog2(MAX_OUTSTANDING):0]     rd_outstanding_o,
    output logic [$clog2(MAX_OUTSTANDING):0]     wr_outstanding_o,
    output logic                                 timeout_o,
    output logic                                 irq_o
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

    logic [OW-1:0] w_rd_out, w_wr_out;
    logic          w_rd_full, w_wr_full;
    logic          w_ar_hs, w_aw_hs, w_r_hs, w_r_last_hs, w_b_hs;
    logic [1:0]    w_err_hs;   // [0] = R, [1] = B

    assign w_rd_full = (w_rd_out == OW'(MAX_OUTSTANDING));
    assign w_wr_full = (w_wr_out == OW'(MAX_OUTSTANDING));

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ~w_rd_full;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & ~w_wr_full;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~w_rd_full;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~w_wr_full;
    end

    assign w_ar_hs     = slv_req_i.ar_valid & ~w_rd_full & mst_resp_i.ar_ready;
    assign w_aw_hs     = slv_req_i.aw_valid & ~w_wr_full & mst_resp_i.aw_ready;
    assign w_r_hs      = mst_resp_i.r_valid & slv_req_i.r_ready;
    assign w_r_last_hs = w_r_hs & mst_resp_i.r.last;
    assign w_b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign w_err_hs[0] = w_r_hs & is_err_resp(mst_resp_i.r.resp);
    assign w_err_hs[1] = w_b_hs & is_err_resp(mst_resp_i.b.resp);

    cva6_axi_err_mon_ctr #(.MAX(MAX_OUTSTANDING), .WIDTH(OW)) u_rd_ctr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_ar_hs),
        .dec_i (w_r_last_hs),
        .cnt_o (w_rd_out)
    );

    cva6_axi_err_mon_ctr #(.MAX(MAX_OUTSTANDING), .WIDTH(OW)) u_wr_ctr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_aw_hs),
        .dec_i (w_b_hs),
        .cnt_o (w_wr_out)
    );

    logic [CNT_WIDTH-1:0] r_err_cnt [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
        always_ff @(posedge clk_i) begin
            if (rst_i || clr_i) begin
                r_err_cnt[gi] <= '0;
            end else if (w_err_hs[gi] && r_err_cnt[gi] != '1) begin
                r_err_cnt[gi] <= r_err_cnt[gi] + 1'b1;
            end
        end
    end

    err_state_e   r_state, w_state_next;
    err_capture_t r_cap, w_cap_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cap   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cap   <= w_cap_next;
        end
    end

    // B wins a same-cycle tie so write errors are never masked by read traffic.
    always_comb begin
        w_state_next = r_state;
        w_cap_next   = r_cap;
        if (clr_i) begin
            w_state_next = IDLE;
            w_cap_next   = '0;
        end else if (r_state == IDLE) begin
            if (w_err_hs[1]) begin
                w_state_next        = CAPTURED;
                w_cap_next.id       = mst_resp_i.b.id;
                w_cap_next.resp     = mst_resp_i.b.resp;
                w_cap_next.is_write = 1'b1;
            end else if (w_err_hs[0]) begin
                w_state_next        = CAPTURED;
                w_cap_next.id       = mst_resp_i.r.id;
                w_cap_next.resp     = mst_resp_i.r.resp;
                w_cap_next.is_write = 1'b0;
            end
        end
    end

    logic w_timeout;

`ifdef CVA6_AXI_ERR_MON_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] r_timer;
    logic          r_timeout;
    logic          w_busy;

    assign w_busy = (w_rd_out | w_wr_out) != '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (clr_i) begin
                r_timeout <= 1'b0;
            end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                r_timeout <= 1'b1;
            end
            if (clr_i || !w_busy || w_r_hs || w_b_hs) begin
                r_timer <= '0;
            end else if (r_timer != TW'(TIMEOUT_CYCLES - 1)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign w_timeout = r_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    logic r_irq;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_irq <= 1'b0;
        else       r_irq <= (r_state == CAPTURED) | w_timeout;
    end

    assign r_err_cnt_o      = r_err_cnt[0];
    assign b_err_cnt_o      = r_err_cnt[1];
    assign err_valid_o      = (r_state == CAPTURED);
    assign err_id_o         = AXI_ID_WIDTH'(r_cap.id);
    assign err_resp_o       = r_cap.resp;
    assign err_is_write_o   = r_cap.is_write;
    assign rd_outstanding_o = w_rd_out;
    assign wr_outstanding_o = w_wr_out;
    assign timeout_o        = w_timeout;
    assign irq_o            = r_irq;

endmodule

// File: tb/tb_cva6_axi_err_mon.sv
// Directed bench for cva6_axi_err_mon: vector table plus hand-written multi-cycle sequences.
module tb_cva6_axi_err_mon;
    import ariane_axi_soc::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] r_err_cnt, b_err_cnt;
    logic       err_valid, err_is_write, timeout, irq;
    logic [7:0] err_id;
    logic [1:0] err_resp;
    logic [3:0] rd_out, wr_out;

    int n_pass  = 0;
    int n_total = 0;

    cva6_axi_err_mon_if slv_bus ();
    cva6_axi_err_mon_if mst_bus ();

    cva6_axi_err_mon #(
        .AXI_ID_WIDTH    (8),
        .MAX_OUTSTANDING (8),
        .CNT_WIDTH       (4),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .slv_req_i        (slv_bus.req),
        .slv_resp_o       (slv_bus.resp),
        .mst_req_o        (mst_bus.req),
        .mst_resp_i       (mst_bus.resp),
        .clr_i            (clr),
        .r_err_cnt_o      (r_err_cnt),
        .b_err_cnt_o      (b_err_cnt),
        .err_valid_o      (err_valid),
        .err_id_o         (err_id),
        .err_resp_o       (err_resp),
        .err_is_write_o   (err_is_write),
        .rd_outstanding_o (rd_out),
        .wr_outstanding_o (wr_out),
        .timeout_o        (timeout),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ar_v, ar_rdy, aw_v, aw_rdy;
        int r_v, r_last, r_resp, r_id;
        int b_v, b_resp, b_id, clr;
        int e_rd, e_wr, e_rc, e_bc;
        int e_ev, e_id, e_resp, e_w, e_irq;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        slv_bus.req           = '0;
        slv_bus.req.r_ready   = 1'b1;
        slv_bus.req.b_ready   = 1'b1;
        mst_bus.resp          = '0;
        clr                   = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        idle_inputs();
        slv_bus.req.ar_valid  = v.ar_v[0];
        mst_bus.resp.ar_ready = v.ar_rdy[0];
        slv_bus.req.aw_valid  = v.aw_v[0];
        mst_bus.resp.aw_ready = v.aw_rdy[0];
        mst_bus.resp.r_valid  = v.r_v[0];
        mst_bus.resp.r.last   = v.r_last[0];
        mst_bus.resp.r.resp   = 2'(v.r_resp);
        mst_bus.resp.r.id     = 8'(v.r_id);
        mst_bus.resp.b_valid  = v.b_v[0];
        mst_bus.resp.b.resp   = 2'(v.b_resp);
        mst_bus.resp.b.id     = 8'(v.b_id);
        clr                   = v.clr[0];
    endtask

    initial begin
        vecs = '{
            '{1,1,0,0, 0,0,0,'h00, 0,0,'h00, 0, 1,0,0,0, 0,'h00,0,0, 0},
            '{1,1,0,0, 0,0,0,'h00, 0,0,'h00, 0, 2,0,0,0, 0,'h00,0,0, 0},
            '{1,1,0,0, 0,0,0,'h00, 0,0,'h00, 0, 3,0,0,0, 0,'h00,0,0, 0},
            '{1,1,0,0, 1,1,0,'h01, 0,0,'h00, 0, 3,0,0,0, 0,'h00,0,0, 0},
            '{0,0,0,0, 1,1,0,'h01, 0,0,'h00, 0, 2,0,0,0, 0,'h00,0,0, 0},
            '{0,0,0,0, 1,1,0,'h01, 0,0,'h00, 0, 1,0,0,0, 0,'h00,0,0, 0},
            '{0,0,0,0, 1,1,3,'h12, 0,0,'h00, 0, 0,0,1,0, 1,'h12,3,0, 0},
            '{0,0,1,1, 0,0,0,'h00, 0,0,'h00, 0, 0,1,1,0, 1,'h12,3,0, 1},
            '{0,0,0,0, 0,0,0,'h00, 1,2,'h05, 0, 0,0,1,1, 1,'h12,3,0, 1},
            '{0,0,0,0, 0,0,0,'h00, 0,0,'h00, 1, 0,0,0,0, 0,'h00,0,0, 1},
            '{1,1,1,1, 0,0,0,'h00, 0,0,'h00, 0, 1,1,0,0, 0,'h00,0,0, 0},
            '{0,0,0,0, 1,1,2,'h33, 1,3,'h44, 0, 0,0,1,1, 1,'h44,3,1, 0},
            '{0,0,1,1, 0,0,0,'h00, 0,0,'h00, 0, 0,1,1,1, 1,'h44,3,1, 1},
            '{0,0,0,0, 0,0,0,'h00, 1,2,'h07, 1, 0,0,0,0, 0,'h00,0,0, 1},
            '{1,1,0,0, 0,0,0,'h00, 0,0,'h00, 0, 1,0,0,0, 0,'h00,0,0, 0},
            '{0,0,0,0, 1,0,2,'h21, 0,0,'h00, 0, 1,0,1,0, 1,'h21,2,0, 0},
            '{0,0,0,0, 1,1,1,'h21, 0,0,'h00, 0, 0,0,1,0, 1,'h21,2,0, 1},
            '{0,0,0,0, 0,0,0,'h00, 0,0,'h00, 1, 0,0,0,0, 0,'h00,0,0, 1},
            '{0,0,0,0, 0,0,0,'h00, 0,0,'h00, 0, 0,0,0,0, 0,'h00,0,0, 0},
            '{1,0,0,0, 0,0,0,'h00, 0,0,'h00, 0, 0,0,0,0, 0,'h00,0,0, 0}
        };

        // Reset state
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rd_out", rd_out, 0);
        chk("rst_wr_out", wr_out, 0);
        chk("rst_r_cnt", r_err_cnt, 0);
        chk("rst_b_cnt", b_err_cnt, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_id", err_id, 0);
        chk("rst_irq", irq, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        $display("reset applied and released");

        // Vector table: one clock per record, state checked after the edge
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i]);
            tick();
            idle_inputs();
            $display("vec %0d: rd=%0d wr=%0d rcnt=%0d bcnt=%0d ev=%0b id=%0h resp=%0d w=%0b irq=%0b",
                     i, rd_out, wr_out, r_err_cnt, b_err_cnt, err_valid, err_id, err_resp, err_is_write, irq);
            chk($sformatf("v%0d_rd_out", i), rd_out, 64'(vecs[i].e_rd));
            chk($sformatf("v%0d_wr_out", i), wr_out, 64'(vecs[i].e_wr));
            chk($sformatf("v%0d_r_cnt", i), r_err_cnt, 64'(vecs[i].e_rc));
            chk($sformatf("v%0d_b_cnt", i), b_err_cnt, 64'(vecs[i].e_bc));
            chk($sformatf("v%0d_err_valid", i), err_valid, 64'(vecs[i].e_ev));
            chk($sformatf("v%0d_err_id", i), err_id, 64'(vecs[i].e_id));
            chk($sformatf("v%0d_err_resp", i), err_resp, 64'(vecs[i].e_resp));
            chk($sformatf("v%0d_err_is_write", i), err_is_write, 64'(vecs[i].e_w));
            chk($sformatf("v%0d_irq", i), irq, 64'(vecs[i].e_irq));
            chk($sformatf("v%0d_timeout", i), timeout, 0);
        end

        // Pass-through of untouched channel fields
        slv_bus.req.ar.id      = 8'h5A;
        slv_bus.req.w_valid    = 1'b1;
        mst_bus.resp.r.data    = 64'hDEAD_BEEF_0123_4567;
        mst_bus.resp.w_ready   = 1'b1;
        #1;
        chk("pt_ar_id", mst_bus.req.ar.id, 8'h5A);
        chk("pt_w_valid", mst_bus.req.w_valid, 1);
        chk("pt_r_data", slv_bus.resp.r.data, 64'hDEAD_BEEF_0123_4567);
        chk("pt_w_ready", slv_bus.resp.w_ready, 1);
        idle_inputs();
        $display("pass-through fields checked");

        // Fill to MAX_OUTSTANDING, 9th AR stalls, one R-last frees a slot
        slv_bus.req.ar_valid  = 1'b1;
        mst_bus.resp.ar_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("full_rd_out", rd_out, 8);
        chk("full_mst_ar_valid", mst_bus.req.ar_valid, 0);
        chk("full_slv_ar_ready", slv_bus.resp.ar_ready, 0);
        tick();
        chk("stall_rd_out", rd_out, 8);
        mst_bus.resp.r_valid = 1'b1;
        mst_bus.resp.r.last  = 1'b1;
        tick();
        chk("freed_rd_out", rd_out, 7);
        mst_bus.resp.r_valid = 1'b0;
        #1;
        chk("freed_mst_ar_valid", mst_bus.req.ar_valid, 1);
        chk("freed_slv_ar_ready", slv_bus.resp.ar_ready, 1);
        tick();
        chk("ninth_ar_rd_out", rd_out, 8);
        slv_bus.req.ar_valid = 1'b0;
        mst_bus.resp.r_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("drained_rd_out", rd_out, 0);
        idle_inputs();
        $display("outstanding cap sequence done");

        // 20 errored B responses against a 4-bit counter
        slv_bus.req.aw_valid  = 1'b1;
        mst_bus.resp.aw_ready = 1'b1;
        mst_bus.resp.b_valid  = 1'b1;
        mst_bus.resp.b.resp   = RESP_SLVERR;
        mst_bus.resp.b.id     = 8'h09;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) chk("sat_b_cnt_15", b_err_cnt, 15);
        end
        chk("sat_b_cnt_20", b_err_cnt, 15);
        chk("sat_wr_out", wr_out, 0);
        chk("sat_err_is_write", err_is_write, 1);
        chk("sat_err_id", err_id, 8'h09);
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_b_cnt", b_err_cnt, 0);
        chk("clr_r_cnt", r_err_cnt, 0);
        chk("clr_err_valid", err_valid, 0);
        $display("saturation and clear sequence done");

        // Watchdog: one AW with no B
        tick();
        slv_bus.req.aw_valid  = 1'b1;
        mst_bus.resp.aw_ready = 1'b1;
        tick();
        idle_inputs();
        chk("wd_wr_out", wr_out, 1);
        for (int i = 0; i < 15; i++) tick();
        chk("wd_timeout_15", timeout, 0);
        tick();
`ifdef CVA6_AXI_ERR_MON_TIMEOUT_EN
        chk("wd_timeout_16", timeout, 1);
`else
        chk("wd_timeout_16", timeout, 0);
`endif
        mst_bus.resp.b_valid = 1'b1;
        tick();
        idle_inputs();
        chk("wd_wr_drained", wr_out, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("wd_timeout_clr", timeout, 0);
        $display("watchdog sequence done");

        // Reset mid-transaction discards outstanding counts
        slv_bus.req.ar_valid  = 1'b1;
        mst_bus.resp.ar_ready = 1'b1;
        tick();
        tick();
        idle_inputs();
        chk("mid_rd_out", rd_out, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_rd_out", rd_out, 0);
        chk("mid_rst_irq", irq, 0);
        $display("mid-transaction reset done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
